// File: rtl/mux_5b_pkg.sv
// Shared constants for the register-address selector.
package mux_5b_pkg;

  // Register-file address width (default data width of the selector).
  localparam int REG_ADDR_W = 5;

  // Select encoding for the choose input.
  localparam logic SEL_SRC1 = 1'b0;
  localparam logic SEL_SRC2 = 1'b1;

endpackage

// File: rtl/mux_5b_mux2.sv
// Width-generic combinational 2:1 selector.
module mux2
  import mux_5b_pkg::*;
#(
  parameter int WIDTH = REG_ADDR_W
) (
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             choose,
  output logic [WIDTH-1:0] result
);

  // An unknown select resolves to src1; the output is don't-care then, and a
  // plain if/else keeps synthesis to a clean 2:1 select.
  always_comb begin
    if (choose == SEL_SRC2) begin
      result = src2;
    end else begin
      result = src1;
    end
  end

endmodule

// File: rtl/mux_5b.sv
// 2:1 selector for register-address fields with a registered copy for the
// next pipeline stage. The combinational output stays live during reset.
module mux_5b
  import mux_5b_pkg::*;
#(
  parameter int WIDTH = REG_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Src1,
  input  logic [WIDTH-1:0] Src2,
  input  logic             choose,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_q,
  output logic             choose_q
);

  logic [WIDTH-1:0] result_c;

  mux2 #(
    .WIDTH (WIDTH)
  ) u_mux2 (
    .src1   (Src1),
    .src2   (Src2),
    .choose (choose),
    .result (result_c)
  );

  // Zero-latency datapath output.
  assign result = result_c;

  // Output register stage: loads every cycle, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      choose_q <= SEL_SRC1;
    end else begin
      result_q <= result_c;
      choose_q <= choose;
    end
  end

endmodule

// File: tb/tb_mux_5b.sv
// Directed self-checking bench for mux_5b.
module tb_mux_5b;

  logic       clk;
  logic       rst;
  logic [4:0] Src1;
  logic [4:0] Src2;
  logic       choose;
  logic [4:0] result;
  logic [4:0] result_q;
  logic       choose_q;

  int total = 0;
  int bad   = 0;

  mux_5b dut (
    .clk      (clk),
    .rst      (rst),
    .Src1     (Src1),
    .Src2     (Src2),
    .choose   (choose),
    .result   (result),
    .result_q (result_q),
    .choose_q (choose_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    logic [4:0] prev;
    logic       prev_c;
    logic [4:0] want;

    // reset state and live combinational path at time 0
    rst = 1'b1; Src1 = 5'h07; Src2 = 5'h08; choose = 1'b0;
    #1;
    chk("t0_result", result, 5'h07);
    chk("t0_result_q", result_q, 5'h00);
    chk("t0_choose_q", {4'b0, choose_q}, 5'h00);

    @(negedge clk); rst = 1'b0;

    // select Src2, then registered copy one edge later
    @(negedge clk); Src1 = 5'h09; Src2 = 5'h0A; choose = 1'b1;
    #1;
    chk("sel2_result", result, 5'h0A);
    chk("sel2_result_q_pre", result_q, 5'h07);
    @(posedge clk); #1;
    chk("sel2_result_q", result_q, 5'h0A);
    chk("sel2_choose_q", {4'b0, choose_q}, 5'h01);

    // async reset between edges
    @(negedge clk); #2; rst = 1'b1;
    #1;
    chk("arst_result_q", result_q, 5'h00);
    chk("arst_choose_q", {4'b0, choose_q}, 5'h00);
    chk("arst_result", result, 5'h0A);

    // result stays live while registers hold reset
    Src1 = 5'h1F; Src2 = 5'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); choose = i[0];
      #1;
      chk("rst_live_result", result, i[0] ? 5'h00 : 5'h1F);
      chk("rst_hold_result_q", result_q, 5'h00);
    end

    // release reset, first edge loads
    @(negedge clk); rst = 1'b0; choose = 1'b0; Src1 = 5'h15;
    @(posedge clk); #1;
    chk("rel_result_q", result_q, 5'h15);
    chk("rel_choose_q", {4'b0, choose_q}, 5'h00);

    // toggle select each cycle: result_q lags result by one cycle
    @(negedge clk); Src1 = 5'h1F; Src2 = 5'h00;
    prev = 5'h15; prev_c = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      choose = i[0];
      want = i[0] ? 5'h00 : 5'h1F;
      #1;
      chk("tog_result", result, want);
      chk("tog_result_q_lag", result_q, prev);
      chk("tog_choose_q_lag", {4'b0, choose_q}, {4'b0, prev_c});
      prev = want; prev_c = i[0];
    end
    @(posedge clk); #1;
    chk("tog_result_q_last", result_q, prev);

    // unselected input is ignored (choose=0)
    @(negedge clk); choose = 1'b0; Src1 = 5'h0C; Src2 = 5'h03;
    @(posedge clk);
    @(negedge clk); Src2 = 5'h1E;
    #1;
    chk("ign2_result", result, 5'h0C);
    @(posedge clk); #1;
    chk("ign2_result_q", result_q, 5'h0C);

    // unselected input is ignored (choose=1)
    @(negedge clk); choose = 1'b1; Src1 = 5'h11; Src2 = 5'h16;
    @(posedge clk);
    @(negedge clk); Src1 = 5'h01;
    #1;
    chk("ign1_result", result, 5'h16);
    @(posedge clk); #1;
    chk("ign1_result_q", result_q, 5'h16);
    chk("ign1_choose_q", {4'b0, choose_q}, 5'h01);

    // reset asserted at a clock edge wins over the load
    @(negedge clk); Src2 = 5'h1B;
    @(posedge clk); rst = 1'b1;
    #1;
    chk("edge_rst_result_q", result_q, 5'h00);
    chk("edge_rst_choose_q", {4'b0, choose_q}, 5'h00);
    chk("edge_rst_result", result, 5'h1B);

    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_result_q", result_q, 5'h1B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
